ct_pt_mult_seq: RTL
===================

# ct_pt_mult_seq

Sequential, lane-parametrised successor to the combinational ciphertext × plaintext slot multiplier. It accepts one ciphertext (A, B) and one plaintext Γ per transaction over a valid/ready handshake. It processes LANES slots per cycle through a 2-stage modular pipeline and returns the result ciphertext over a second valid/ready handshake. A mode input selects slot-wise multiply (A⊙Γ, B⊙Γ) or plaintext add (A, B+Γ), both mod Q. It sits between the ciphertext register file and the evaluator datapath.

## Interface
- N, default N_SLOTS_L: slots per polynomial vector.
- W, default W_BITS_L: residue word width.
- Q, default Q_MOD_L: modulus; must satisfy 2 ≤ Q < 2^W.
- LANES, default 2: slots processed per cycle; N % LANES == 0 is required (elaboration-time assertion).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept a transaction.
- in_op  in  ctpt_op_t  CTPT_MUL or CTPT_ADD; sampled with the input data.
- in_ct  in  CT_t  ciphertext (A, B), N words of W bits each.
- in_gamma  in  PT_t  plaintext Γ, N words of W bits.
- out_valid  out  1  result held on out_ct.
- out_ready  in  1  consumer accepts the result.
- out_ct  out  CT_t  result ciphertext.
- busy  out  1  high in RUN, DRAIN and DONE.

## Operation
- Inputs are unsigned residues. Out-of-range inputs (≥ Q) are still reduced correctly, because reduction is applied to the full-width result.
- MUL: each lane forms a 2W-bit unsigned product a·γ and b·γ. The result is the product mod Q, always in [0, Q).
- ADD: A slots pass unchanged through the pipeline, reduced mod Q. B slots form a (W+1)-bit sum b+γ, and the result is that sum mod Q.
- On accept (in_valid && in_ready), the block registers in_ct, in_gamma and in_op internally. Later changes on the inputs have no effect.
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE: in_ready=1. On accept, go to RUN with slot index idx=0.
  - RUN: issue slots idx..idx+LANES-1 into lane stage 1, then idx += LANES. After C=N/LANES cycles, go to DRAIN.
  - DRAIN: exactly 2 cycles while the pipeline empties. Stage-2 outputs write into the output register at their slot index. Then go to DONE.
  - DONE: out_valid=1 and out_ct is stable. On out_ready, go to IDLE.
- in_ready=1 only in IDLE. There is no input acceptance in the same cycle as the output handshake; the next accept occurs at the earliest one cycle later.
- Reset (async, any state): state goes to IDLE, idx=0, pipeline valid bits clear, out_ct=0. An in-flight transaction is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_ct all zeros.
- Let the accept cycle be cycle 0. RUN occupies cycles 1..C, DRAIN occupies cycles C+1..C+2, and out_valid first goes high in cycle C+3.
- Latency examples: LANES=N gives C=1 and out_valid in cycle 4; LANES=1 gives C=N.
- Throughput is one transaction per C+4 cycles when out_ready is held high.
- Lane pipeline:
  - Stage 1 registers the raw product or sum.
  - Stage 2 registers the mod-Q result.
- out_valid is held indefinitely under backpressure. out_ct does not change while out_valid=1.

## Structure
- Add to the shared package (types.svh): LANES_L, and enum ctpt_op_t {CTPT_MUL, CTPT_ADD}. Reuse the existing CT_t, PT_t and word_t.
- Sub-module mod_lane_q (parameters W, Q): a 2-stage pipeline with an op input, operands a and g, and a valid bit carried alongside the data.
- The top module instantiates 2·LANES copies: one per A lane and one per B lane.

## Test plan
Common parameters: N=8, W=16, Q=97, LANES=2 unless stated.
1. MUL with A[i]=i+1, B[i]=96, Γ[i]=50 -> A'[i]=(i+1)·50 mod 97 (for example A'[0]=50, A'[1]=3) and B'[i]=47. out_valid rises in cycle 7.
2. ADD with A[i]=i, B[i]=90, Γ[i]=10 -> A'[i]=i and B'[i]=3.
3. Boundary, all inputs equal to 96:
   - MUL -> every slot equals 1.
   - ADD -> A'=96 and B'=95.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_ct is stable, and in_ready=0 while a second in_valid is held. The second transaction is accepted in the cycle after the output handshake and produces a correct result.
5. Latency sweep: LANES=8 -> out_valid in cycle 4; LANES=1 -> out_valid in cycle 11. Results are identical to scenario 1.
6. Reset mid-operation: assert rst_n=0 in RUN cycle 2 -> immediately out_valid=0, busy=0, in_ready=1 and out_ct=0. A following MUL transaction then completes correctly.

Source files
------------

// File: rtl/ct_pt_mult_seq_pkg.sv
// Shared types and defaults for the sequential ciphertext x plaintext slot multiplier.
// Slot vectors are packed word arrays; ciphertexts carry the A and B polynomials.
package ct_pt_mult_seq_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;
  localparam int Q_MOD_L   = 97;
  localparam int LANES_L   = 2;

  typedef logic [W_BITS_L-1:0] word_t;

  typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] PT_t;

  typedef struct packed {
    PT_t a;
    PT_t b;
  } CT_t;

  typedef enum logic {
    CTPT_MUL = 1'b0,
    CTPT_ADD = 1'b1
  } ctpt_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctpt_state_t;

endpackage

// File: rtl/ct_pt_mult_seq_lane.sv
// One modular lane: stage 1 holds the raw product or sum, stage 2 the residue mod Q.
// The valid bit travels with the data so the top knows when stage 2 is meaningful.
module mod_lane_q
  import ct_pt_mult_seq_pkg::*;
#(
  parameter int W = W_BITS_L,
  parameter int Q = Q_MOD_L
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  ctpt_op_t     op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] g_i,
  output logic         valid_o,
  output logic [W-1:0] res_o
);

  localparam int RW = 2 * W;
  localparam logic [RW-1:0] Q_RW = RW'(Q);

  logic [RW-1:0] raw_d, raw_q;
  logic [W-1:0]  res_d, res_q;
  logic          s1_vld_q, s2_vld_q;
  logic [RW-1:0] a_ext, g_ext;

  assign a_ext = {{W{1'b0}}, a_i};
  assign g_ext = {{W{1'b0}}, g_i};

  always_comb begin
    raw_d = a_ext + g_ext;
    if (op_i == CTPT_MUL) raw_d = a_ext * g_ext;
    // Reducing the full-width value keeps out-of-range operands correct.
    res_d = W'(raw_q % Q_RW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      res_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= valid_i;
      s2_vld_q <= s1_vld_q;
      if (valid_i)  raw_q <= raw_d;
      if (s1_vld_q) res_q <= res_d;
    end
  end

  assign valid_o = s2_vld_q;
  assign res_o   = res_q;

endmodule

// File: rtl/ct_pt_mult_seq.sv
// Sequential ciphertext x plaintext slot engine: MUL gives (A*G, B*G), ADD gives (A, B+G), mod Q.
// LANES slots per cycle are pushed through 2*LANES two-stage lanes into a held output register.
module ct_pt_mult_seq
  import ct_pt_mult_seq_pkg::*;
#(
  parameter int N     = N_SLOTS_L,
  parameter int W     = W_BITS_L,
  parameter int Q     = Q_MOD_L,
  parameter int LANES = LANES_L
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  ctpt_op_t    in_op,
  input  CT_t         in_ct,
  input  PT_t         in_gamma,
  output logic        out_valid,
  input  logic        out_ready,
  output CT_t         out_ct,
  output logic        busy,
  output ctpt_state_t dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and out_ct is frozen there.

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - LANES);
  localparam logic [SW-1:0] STEP     = SW'(LANES);

  if (N % LANES != 0) begin : g_bad_lanes
    $error("N must be a multiple of LANES");
  end
  if (N != N_SLOTS_L || W != W_BITS_L) begin : g_bad_shape
    $error("N and W must match the package slot types");
  end
  if (Q < 2 || longint'(Q) >= (longint'(1) << W)) begin : g_bad_q
    $error("Q must satisfy 2 <= Q < 2**W");
  end

  ctpt_state_t   state_d, state_q;
  logic [SW-1:0] idx_d, idx_q;
  logic          drain_d, drain_q;
  logic          issue, accept;

  CT_t           ct_q;
  PT_t           gamma_q;
  ctpt_op_t      op_q;
  logic [SW-1:0] idx_s1_q, idx_s2_q;
  CT_t           out_d, out_q;

  logic [W-1:0]  a_res [LANES];
  logic [W-1:0]  b_res [LANES];
  logic          a_vld [LANES];
  logic          b_vld [LANES];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + STEP;
        end
      end
      ST_DRAIN: begin
        // Two cycles: the last issue needs both lane stages before it lands in out_q.
        if (drain_q) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      ct_q     <= '0;
      gamma_q  <= '0;
      op_q     <= CTPT_MUL;
      idx_s1_q <= '0;
      idx_s2_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      idx_s2_q <= idx_s1_q;
      out_q    <= out_d;
      if (issue) idx_s1_q <= idx_q;
      if (accept) begin
        ct_q    <= in_ct;
        gamma_q <= in_gamma;
        op_q    <= in_op;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SW-1:0] slot;
    logic [W-1:0]  a_g;
    assign slot = idx_q + SW'(l);
    // In ADD mode the A lane adds zero, so A passes through and is only reduced.
    assign a_g  = (op_q == CTPT_ADD) ? '0 : gamma_q[slot];

    mod_lane_q #(.W(W), .Q(Q)) u_lane_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (issue),
      .op_i    (op_q),
      .a_i     (ct_q.a[slot]),
      .g_i     (a_g),
      .valid_o (a_vld[l]),
      .res_o   (a_res[l])
    );

    mod_lane_q #(.W(W), .Q(Q)) u_lane_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (issue),
      .op_i    (op_q),
      .a_i     (ct_q.b[slot]),
      .g_i     (gamma_q[slot]),
      .valid_o (b_vld[l]),
      .res_o   (b_res[l])
    );
  end

  always_comb begin
    out_d = out_q;
    for (int l = 0; l < LANES; l++) begin
      if (a_vld[l]) out_d.a[idx_s2_q + SW'(l)] = a_res[l];
      if (b_vld[l]) out_d.b[idx_s2_q + SW'(l)] = b_res[l];
    end
  end

  assign out_ct      = out_q;
  assign dbg_state_o = state_q;

endmodule
